// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for the three-port SRAM arbiter.
// The arbiter connects through the slave modport; the requesters and SRAM connect through master.
interface sram_arbiter_if;
    logic        video_req;
    logic [13:0] video_addr;
    logic [7:0]  video_rdata;
    logic        video_ack;

    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;

    logic        ldr_req;
    logic [18:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_ack;

    logic [18:0] sram_addr;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din;
    logic        sram_drive;
    logic        sram_we_n;

    logic [1:0]  owner;

    modport slave (
        input  video_req, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ldr_req, ldr_addr, ldr_wdata, sram_din,
        output video_rdata, video_ack, cpu_rdata, cpu_ack, ldr_ack,
               sram_addr, sram_dout, sram_drive, sram_we_n, owner
    );

    modport master (
        output video_req, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ldr_req, ldr_addr, ldr_wdata, sram_din,
        input  video_rdata, video_ack, cpu_rdata, cpu_ack, ldr_ack,
               sram_addr, sram_dout, sram_drive, sram_we_n, owner
    );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way SRAM arbiter: video > cpu > loader, with loader anti-starvation.
// Each grant runs a fixed-length access followed by a one-cycle ack.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [4:0]  VIDEO_PAGE    = 5'b00011,
    parameter int unsigned LDR_STARVE    = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);
    localparam int unsigned CYC_W    = 3;
    localparam int unsigned STARVE_W = (LDR_STARVE < 2) ? 1 : $clog2(LDR_STARVE + 1);
    localparam logic [CYC_W-1:0]    CYC_LAST   = CYC_W'(ACCESS_CYCLES);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(LDR_STARVE);

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_VIDEO = 2'd1;
    localparam logic [1:0] OWN_CPU   = 2'd2;
    localparam logic [1:0] OWN_LDR   = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_q, wr_d;
    logic [18:0]         addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                drive_q, drive_d;
    logic                we_n_q, we_n_d;
    logic [7:0]          video_rdata_q, video_rdata_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                video_ack_q, video_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ldr_ack_q, ldr_ack_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cyc_d         = cyc_q;
        starve_d      = starve_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        drive_d       = drive_q;
        we_n_d        = we_n_q;
        video_rdata_d = video_rdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        video_ack_d   = 1'b0;
        cpu_ack_d     = 1'b0;
        ldr_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.ldr_req) starve_d = '0;
                // Loader wins over the CPU only once it has waited out LDR_STARVE CPU grants
                if (bus.video_req) begin
                    owner_d = OWN_VIDEO;
                    addr_d  = {VIDEO_PAGE, bus.video_addr};
                    wr_d    = 1'b0;
                end else if (bus.ldr_req && (starve_q == STARVE_MAX || !bus.cpu_req)) begin
                    owner_d  = OWN_LDR;
                    addr_d   = bus.ldr_addr;
                    dout_d   = bus.ldr_wdata;
                    wr_d     = 1'b1;
                    starve_d = '0;
                end else if (bus.cpu_req) begin
                    owner_d = OWN_CPU;
                    addr_d  = bus.cpu_addr;
                    wr_d    = bus.cpu_we;
                    if (bus.cpu_we) dout_d = bus.cpu_wdata;
                    if (bus.ldr_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
                end
                if (bus.video_req || bus.cpu_req || bus.ldr_req) begin
                    state_d = ACCESS;
                    cyc_d   = CYC_W'(1);
                    drive_d = wr_d;
                end
            end
            ACCESS: begin
                if (cyc_q == CYC_LAST) begin
                    state_d = DONE;
                    cyc_d   = '0;
                    drive_d = 1'b0;
                    we_n_d  = 1'b1;
                    unique case (owner_q)
                        OWN_VIDEO: begin
                            video_ack_d = 1'b1;
                            if (!wr_q) video_rdata_d = bus.sram_din;
                        end
                        OWN_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!wr_q) cpu_rdata_d = bus.sram_din;
                        end
                        OWN_LDR: ldr_ack_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    // Write strobe opens one cycle after address and data settle
                    cyc_d  = cyc_q + 1'b1;
                    we_n_d = !wr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            cyc_q         <= '0;
            starve_q      <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            dout_q        <= '0;
            drive_q       <= 1'b0;
            we_n_q        <= 1'b1;
            video_rdata_q <= '0;
            cpu_rdata_q   <= '0;
            video_ack_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            ldr_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cyc_q         <= cyc_d;
            starve_q      <= starve_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            drive_q       <= drive_d;
            we_n_q        <= we_n_d;
            video_rdata_q <= video_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            video_ack_q   <= video_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            ldr_ack_q     <= ldr_ack_d;
        end
    end

    assign bus.owner       = owner_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dout   = dout_q;
    assign bus.sram_drive  = drive_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.video_rdata = video_rdata_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.video_ack   = video_ack_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.ldr_ack     = ldr_ack_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table plus scoreboarded multi-grant, abort and long-access sequences.
module tb_sram_arbiter;
    logic clk_sys = 1'b0;
    logic rst_n;
    logic rst5_n;
    int   cyc_cnt = 0;

    sram_arbiter_if ba ();
    sram_arbiter_if b5 ();

    sram_arbiter dut_a (.clk_sys(clk_sys), .reset_n(rst_n), .bus(ba.slave));
    sram_arbiter #(.ACCESS_CYCLES(5)) dut_b (.clk_sys(clk_sys), .reset_n(rst5_n), .bus(b5.slave));

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [1:0]  who;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [18:0] exp_addr;
        int          exp_drv;
        int          exp_wel;
        logic [7:0]  exp_vrd;
        logic [7:0]  exp_crd;
    } vec_t;

    typedef struct {
        logic [1:0] owner;
        int         lat;
        int         t_req;
        logic [7:0] vrd;
        logic [7:0] crd;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    vec_t        pv;
    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0, drive_cnt = 0, wel_cnt = 0, addr_bad = 0, dout_bad = 0, prot_bad = 0;
    int          s_acc, s_drv, s_wel, s_addr, s_dout;
    logic        prev_acc = 1'b0;
    logic [18:0] exp_a[4];
    logic [7:0]  exp_d[4];
    int          t0, lat, n_ack, n_own, n_wel, n_drv, n_bad;
    logic        got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] owner, input int l, input int t,
                            input logic [7:0] vrd, input logic [7:0] crd);
        exp_t e;
        e.owner = owner;
        e.lat   = l;
        e.t_req = t;
        e.vrd   = vrd;
        e.crd   = crd;
        sb.push_back(e);
    endtask

    task automatic snapshot();
        s_acc  = acc_cnt;
        s_drv  = drive_cnt;
        s_wel  = wel_cnt;
        s_addr = addr_bad;
        s_dout = dout_bad;
    endtask

    task automatic check_stats(input int e_acc, input int e_drv, input int e_wel);
        check("access_cycles", 32'(acc_cnt - s_acc), 32'(e_acc));
        check("drive_cycles", 32'(drive_cnt - s_drv), 32'(e_drv));
        check("we_n_low_cycles", 32'(wel_cnt - s_wel), 32'(e_wel));
        check("addr_stable", 32'(addr_bad - s_addr), 32'd0);
        check("dout_valid", 32'(dout_bad - s_dout), 32'd0);
    endtask

    // Per-cycle bus observation on the default-parameter arbiter plus scoreboard pop on ack
    task automatic sample_cycle();
        logic       acc;
        logic [2:0] acks;
        logic [2:0] exp_ack;
        exp_t       e;
        acks = {ba.video_ack, ba.cpu_ack, ba.ldr_ack};
        acc  = (ba.owner != 2'd0) && (acks == 3'b000);
        if (acc) begin
            acc_cnt++;
            if (ba.sram_drive) drive_cnt++;
            if (!ba.sram_we_n) wel_cnt++;
            if (ba.sram_addr != exp_a[ba.owner]) addr_bad++;
            if (ba.sram_drive && ba.sram_dout != exp_d[ba.owner]) dout_bad++;
            if (!prev_acc && !ba.sram_we_n) prot_bad++;
        end else if (ba.sram_drive || !ba.sram_we_n) begin
            prot_bad++;
        end
        prev_acc = acc;
        if (acks != 3'b000) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 32'(acks), 32'd0);
            end else begin
                e = sb.pop_front();
                exp_ack = 3'b100 >> (e.owner - 2'd1);
                check("ack_owner", 32'(acks), 32'(exp_ack));
                check("ack_latency", 32'(cyc_cnt - e.t_req), 32'(e.lat));
                check("owner_in_done", 32'(ba.owner), 32'(e.owner));
                check("video_rdata", 32'(ba.video_rdata), 32'(e.vrd));
                check("cpu_rdata", 32'(ba.cpu_rdata), 32'(e.crd));
            end
        end
    endtask

    // Each requester keeps req high until its last expected ack, then drops it on the ack edge
    task automatic wait_acks(input int nv_i, input int nc_i, input int nl_i, input int budget);
        int nv, nc, nl, n;
        nv = nv_i;
        nc = nc_i;
        nl = nl_i;
        n  = 0;
        while ((nv > 0 || nc > 0 || nl > 0) && n < budget) begin
            @(negedge clk_sys);
            n++;
            sample_cycle();
            if (ba.video_ack) nv--;
            if (ba.cpu_ack) nc--;
            if (ba.ldr_ack) nl--;
            @(posedge clk_sys);
            #1;
            if (nv <= 0) ba.video_req = 1'b0;
            if (nc <= 0) ba.cpu_req = 1'b0;
            if (nl <= 0) ba.ldr_req = 1'b0;
        end
        check("ack_timeout", 32'(nv > 0 || nc > 0 || nl > 0), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk_sys);
        #1;
        snapshot();
        exp_a[v.who] = v.exp_addr;
        exp_d[v.who] = v.wdata;
        ba.sram_din  = v.din;
        case (v.who)
            2'd1: begin
                ba.video_addr = v.addr[13:0];
                ba.video_req  = 1'b1;
            end
            2'd2: begin
                ba.cpu_addr  = v.addr;
                ba.cpu_we    = v.we;
                ba.cpu_wdata = v.wdata;
                ba.cpu_req   = 1'b1;
            end
            default: begin
                ba.ldr_addr  = v.addr;
                ba.ldr_wdata = v.wdata;
                ba.ldr_req   = 1'b1;
            end
        endcase
        push_exp(v.who, 3, cyc_cnt, v.exp_vrd, v.exp_crd);
        wait_acks(int'(v.who == 2'd1), int'(v.who == 2'd2), int'(v.who == 2'd3), 12);
        check_stats(2, v.exp_drv, v.exp_wel);
        @(negedge clk_sys);
        check("owner_back_to_idle", 32'(ba.owner), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst5_n = 1'b0;
        ba.video_req = 1'b0; ba.video_addr = '0; ba.cpu_req = 1'b0; ba.cpu_we = 1'b0;
        ba.cpu_addr = '0; ba.cpu_wdata = '0; ba.ldr_req = 1'b0; ba.ldr_addr = '0;
        ba.ldr_wdata = '0; ba.sram_din = '0;
        b5.video_req = 1'b0; b5.video_addr = '0; b5.cpu_req = 1'b0; b5.cpu_we = 1'b0;
        b5.cpu_addr = '0; b5.cpu_wdata = '0; b5.ldr_req = 1'b0; b5.ldr_addr = '0;
        b5.ldr_wdata = '0; b5.sram_din = '0;
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = '0;
            exp_d[i] = '0;
        end

        //         who   we    addr       wdata  din    exp_addr   drv wel vrd    crd
        vecs[0] = '{2'd2, 1'b0, 19'h01234, 8'h00, 8'hA5, 19'h01234, 0, 0, 8'h00, 8'hA5};
        vecs[1] = '{2'd2, 1'b1, 19'h7FFFF, 8'h5A, 8'hEE, 19'h7FFFF, 2, 1, 8'h00, 8'hA5};
        vecs[2] = '{2'd1, 1'b0, 19'h00ABC, 8'h00, 8'h3C, 19'h0CABC, 0, 0, 8'h3C, 8'hA5};
        vecs[3] = '{2'd3, 1'b1, 19'h40001, 8'hC3, 8'hEE, 19'h40001, 2, 1, 8'h3C, 8'hA5};
        vecs[4] = '{2'd1, 1'b0, 19'h03FFF, 8'h00, 8'hFF, 19'h0FFFF, 0, 0, 8'hFF, 8'hA5};
        vecs[5] = '{2'd2, 1'b0, 19'h7FFFF, 8'h00, 8'h81, 19'h7FFFF, 0, 0, 8'hFF, 8'h81};
        vecs[6] = '{2'd2, 1'b1, 19'h00000, 8'hE7, 8'hEE, 19'h00000, 2, 1, 8'hFF, 8'h81};
        pv      = '{2'd2, 1'b0, 19'h2AAAA, 8'h00, 8'h5C, 19'h2AAAA, 0, 0, 8'h00, 8'h5C};

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_owner", 32'(ba.owner), 32'd0);
        check("rst_acks", 32'({ba.video_ack, ba.cpu_ack, ba.ldr_ack}), 32'd0);
        check("rst_we_n", 32'(ba.sram_we_n), 32'd1);
        check("rst_drive", 32'(ba.sram_drive), 32'd0);
        check("rst_addr", 32'(ba.sram_addr), 32'd0);
        check("rst_dout", 32'(ba.sram_dout), 32'd0);
        check("rst_video_rdata", 32'(ba.video_rdata), 32'd0);
        check("rst_cpu_rdata", 32'(ba.cpu_rdata), 32'd0);
        check("rst_b5_we_n", 32'(b5.sram_we_n), 32'd1);
        @(posedge clk_sys);
        #1;
        rst_n  = 1'b1;
        rst5_n = 1'b1;

        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // Simultaneous video and CPU: video first, CPU granted right after video DONE
        @(posedge clk_sys);
        #1;
        snapshot();
        exp_a[1] = 19'h0C010;
        exp_a[2] = 19'h00055;
        exp_d[2] = 8'h99;
        ba.sram_din   = 8'h77;
        ba.video_addr = 14'h0010;
        ba.cpu_addr   = 19'h00055;
        ba.cpu_we     = 1'b1;
        ba.cpu_wdata  = 8'h99;
        ba.video_req  = 1'b1;
        ba.cpu_req    = 1'b1;
        push_exp(2'd1, 3, cyc_cnt, 8'h77, 8'h81);
        push_exp(2'd2, 7, cyc_cnt, 8'h77, 8'h81);
        wait_acks(1, 1, 0, 20);
        check_stats(4, 2, 1);

        // CPU held with loader waiting: four CPU grants, then loader, twice over
        @(posedge clk_sys);
        #1;
        snapshot();
        exp_a[2] = 19'h00100;
        exp_a[3] = 19'h00200;
        exp_d[3] = 8'h22;
        ba.sram_din  = 8'h11;
        ba.cpu_we    = 1'b0;
        ba.cpu_addr  = 19'h00100;
        ba.ldr_addr  = 19'h00200;
        ba.ldr_wdata = 8'h22;
        ba.cpu_req   = 1'b1;
        ba.ldr_req   = 1'b1;
        for (int i = 0; i < 10; i++)
            push_exp((i == 4 || i == 9) ? 2'd3 : 2'd2, 3 + 4 * i, cyc_cnt, 8'h77, 8'h11);
        wait_acks(0, 8, 2, 60);
        check_stats(20, 4, 2);

        // Reset asserted in the second cycle of a CPU write
        @(posedge clk_sys);
        #1;
        ba.cpu_addr  = 19'h00ABC;
        ba.cpu_we    = 1'b1;
        ba.cpu_wdata = 8'h66;
        ba.cpu_req   = 1'b1;
        @(posedge clk_sys);
        #1;
        @(posedge clk_sys);
        #2;
        check("abort_pre_we_n", 32'(ba.sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_we_n", 32'(ba.sram_we_n), 32'd1);
        check("abort_drive", 32'(ba.sram_drive), 32'd0);
        check("abort_owner", 32'(ba.owner), 32'd0);
        check("abort_addr", 32'(ba.sram_addr), 32'd0);
        ba.cpu_req = 1'b0;
        ba.cpu_we  = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        n_ack = 0;
        n_own = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (ba.video_ack || ba.cpu_ack || ba.ldr_ack) n_ack++;
            if (ba.owner != 2'd0) n_own++;
        end
        check("abort_no_ack", 32'(n_ack), 32'd0);
        check("abort_stays_idle", 32'(n_own), 32'd0);
        apply_vec(pv);

        // Five-cycle access: loader write on the second arbiter
        @(posedge clk_sys);
        #1;
        b5.ldr_addr  = 19'h12345;
        b5.ldr_wdata = 8'h3A;
        b5.ldr_req   = 1'b1;
        t0 = cyc_cnt;
        got = 1'b0;
        lat = 0;
        n_wel = 0;
        n_drv = 0;
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (b5.ldr_ack) begin
                got = 1'b1;
                lat = cyc_cnt - t0;
                break;
            end else if (b5.owner == 2'd3) begin
                if (b5.sram_drive) n_drv++;
                if (!b5.sram_we_n) n_wel++;
                if (b5.sram_addr != 19'h12345 || (b5.sram_drive && b5.sram_dout != 8'h3A)) n_bad++;
            end
        end
        @(posedge clk_sys);
        #1;
        b5.ldr_req = 1'b0;
        check("b5_ack_seen", 32'(got), 32'd1);
        check("b5_ack_latency", 32'(lat), 32'd6);
        check("b5_drive_cycles", 32'(n_drv), 32'd5);
        check("b5_we_n_low_cycles", 32'(n_wel), 32'd4);
        check("b5_addr_dout", 32'(n_bad), 32'd0);

        check("protocol_outside_access", 32'(prot_bad), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The module SHALL have parameter ACCESS_CYCLES, default 2, giving the cycles per SRAM access (legal range 2..7).
REQ-002 The module SHALL have parameter VIDEO_PAGE, default 5'b00011, giving the SRAM address bits [18:14] for video fetches.
REQ-003 The module SHALL have parameter LDR_STARVE, default 4, giving the consecutive CPU grants after which a waiting loader is served.
REQ-004 The module SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 The module SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port video_req  in  1  video fetch request (level).
REQ-007 The module SHALL have port video_addr  in  14  video byte address within VIDEO_PAGE.
REQ-008 The module SHALL have port video_rdata  out  8  registered video read data.
REQ-009 The module SHALL have port video_ack  out  1  one-cycle completion pulse.
REQ-010 The module SHALL have ports cpu_req, cpu_we (in 1 each), cpu_addr (in 19), cpu_wdata (in 8), cpu_rdata (out 8, registered) and cpu_ack (out 1): the CPU request, write strobe, address, write data, read data and one-cycle completion pulse.
REQ-011 The module SHALL have ports ldr_req (in 1), ldr_addr (in 19), ldr_wdata (in 8) and ldr_ack (out 1): a write-only loader request, address, data and one-cycle completion pulse.
REQ-012 The module SHALL have ports sram_addr (out 19), sram_dout (out 8), sram_din (in 8), sram_drive (out 1, data-bus output enable) and sram_we_n (out 1, active-low write strobe).
REQ-013 The module SHALL have port owner  out  2  current grant: 0 none, 1 video, 2 cpu, 3 loader.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-015 In IDLE, requests SHALL be sampled, and any active request SHALL move the FSM to ACCESS on the next edge with owner latched.
REQ-016 Priority SHALL be fixed as video > cpu > loader, except REQ-017.
REQ-017 When the starvation counter equals LDR_STARVE and ldr_req is high, the loader SHALL win over the CPU but not over video.
REQ-018 The starvation counter SHALL increment on each CPU grant while ldr_req is high, and SHALL clear on a loader grant or whenever ldr_req is low in IDLE; it saturates at LDR_STARVE.
REQ-019 ACCESS SHALL last exactly ACCESS_CYCLES cycles, timed by a cycle counter.
REQ-020 sram_addr SHALL be held constant for the whole ACCESS state: {VIDEO_PAGE, video_addr} for video, cpu_addr for CPU, ldr_addr for loader.
REQ-021 For writes (cpu_we=1 or loader), sram_drive SHALL be 1 and sram_dout valid for all ACCESS cycles, while sram_we_n SHALL be 0 from the second through the last ACCESS cycle only.
REQ-022 For reads, sram_din SHALL be captured into the owner's rdata register at the edge ending the last ACCESS cycle, and the other rdata register SHALL be unchanged.
REQ-023 DONE SHALL last one cycle, assert exactly the owner's ack, and return to IDLE with owner=0.
REQ-024 Latency from a request seen in an idle IDLE cycle to its ack SHALL be ACCESS_CYCLES+1 cycles.
REQ-025 Requesters SHALL hold req, address and data until ack, and SHALL drop req on the edge where ack is high; a req still high in the following IDLE SHALL be served as a new request.
REQ-026 Requests arriving during ACCESS or DONE SHALL wait for the next IDLE, and an ongoing access SHALL never be pre-empted, including by video.
REQ-027 Outside write ACCESS cycles, sram_drive SHALL be 0 and sram_we_n SHALL be 1.

Reset
REQ-028 While reset_n=0, the FSM SHALL be IDLE, owner=0, all acks=0, sram_we_n=1, sram_drive=0, sram_addr=0, sram_dout=0, rdata registers=0, and all counters=0.
REQ-029 Asserting reset_n mid-access SHALL abort the access immediately (sram_we_n=1 asynchronously) with no ack generated.

Verification
REQ-030 Idle CPU read of addr 0x01234 with sram_din=0xA5 -> sram_addr=0x01234 for 2 cycles, cpu_rdata=0xA5, cpu_ack 3 cycles after req.
REQ-031 video_req and cpu_req raised in the same cycle -> video served first with sram_addr={5'b00011, video_addr}; the CPU is served immediately after the video DONE.
REQ-032 CPU write of 0x5A to 0x7FFFF -> sram_drive=1 for 2 cycles, sram_we_n=0 only in the 2nd cycle, sram_dout=0x5A, one cpu_ack.
REQ-033 CPU req held continuously with ldr_req high -> the 5th grant goes to the loader after 4 CPU grants, then the counter returns to 0.
REQ-034 reset_n pulled low in the 2nd cycle of a CPU write -> sram_we_n=1 at once, no cpu_ack, FSM in IDLE after reset release.
REQ-035 ACCESS_CYCLES=5 loader write -> sram_we_n low for 4 cycles, ldr_ack 6 cycles after req.
